inst_prefetch_queue: RTL and testbench

Instruction prefetch queue between a variable-latency instruction memory and the IF/ID pipeline register of the 5-stage MIPS core. It runs ahead of decode, buffers up to DEPTH fetched words tagged with their PC, and presents the head entry to IF/ID. It takes branch/jump redirects from ID, flushes stale entries, and discards an in-flight response.

---
 rtl/inst_prefetch_queue.sv | 141 ++++++++++++++
 tb/tb_inst_prefetch_queue.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_prefetch_queue.sv
// rtl/inst_prefetch_queue.sv - instruction prefetch queue feeding IF/ID, one outstanding fetch.
// Optional same-cycle response bypass to the head outputs: define PFQ_BYPASS_EN.
module inst_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        pop_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   pc_mem_q   [DEPTH];
  logic [31:0]   inst_mem_q [DEPTH];

  logic head_valid;
  logic grant;
  logic rsp;
  logic bypass;
  logic push;
  logic pop;

  assign head_valid = (count_q != '0);
  assign mem_req_o  = (state_q == S_FETCH) && start_i && (count_q < CW'(DEPTH));
  assign mem_addr_o = fetch_pc_q;
  assign grant      = mem_req_o && mem_gnt_i;
  assign rsp        = (state_q == S_WAIT) && mem_rvalid_i && !redirect_i;
`ifdef PFQ_BYPASS_EN
  assign bypass     = rsp && !head_valid;
`else
  assign bypass     = 1'b0;
`endif
  // A bypassed word that IF/ID takes the same cycle never enters storage.
  assign push       = rsp && !(bypass && pop_i);
  assign pop        = pop_i && head_valid && !redirect_i;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_FETCH;
      S_FETCH: begin
        if (grant) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          req_pc_d   = fetch_pc_q;
          state_d    = S_WAIT;
        end else if (!start_i) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT:  if (mem_rvalid_i) state_d = start_i ? S_FETCH : S_IDLE;
      default: if (mem_rvalid_i) state_d = S_FETCH;
    endcase
    // A response landing in the redirect cycle retires the outstanding fetch, so no drain is needed.
    if (redirect_i) begin
      fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
      if ((state_q == S_WAIT && !mem_rvalid_i) || grant) state_d = S_DRAIN;
    end
  end

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (redirect_i) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      if (push && !redirect_i) begin
        pc_mem_q[wr_ptr_q]   <= req_pc_q;
        inst_mem_q[wr_ptr_q] <= mem_rdata_i;
      end
    end
  end

  always_comb begin
    inst_valid_o = head_valid;
    inst_o       = head_valid ? inst_mem_q[rd_ptr_q] : 32'h0;
    inst_pc_o    = head_valid ? pc_mem_q[rd_ptr_q] : 32'h0;
    pc_plus4_o   = head_valid ? pc_mem_q[rd_ptr_q] + 32'd4 : 32'h0;
    if (bypass) begin
      inst_valid_o = 1'b1;
      inst_o       = mem_rdata_i;
      inst_pc_o    = req_pc_q;
      pc_plus4_o   = req_pc_q + 32'd4;
    end
  end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// tb/tb_inst_prefetch_queue.sv - directed-vector bench for inst_prefetch_queue.
// Expectations follow PFQ_BYPASS_EN when defined.
module tb_inst_prefetch_queue;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        pop_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic [31:0] pc_plus4_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  int          n_cmp;
  int          n_err;
  logic        pend;
  logic [31:0] pend_addr;
  logic [31:0] exp_pc;
  logic        byp;

  inst_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .pop_i         (pop_i),
    .inst_valid_o  (inst_valid_o),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o),
    .pc_plus4_o    (pc_plus4_o),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic logic [31:0] dat(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b0; start_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; pop_i = 1'b0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; pend = 1'b0; pend_addr = '0;
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_valid", 32'(inst_valid_o), 32'd0);
    chk("rst_inst", inst_o, 32'h0);
    chk("rst_req", 32'(mem_req_o), 32'd0);
    rst_i = 1'b1;
  endtask

  // One negedge of an ideal memory: grant on request, respond the following cycle.
  task automatic auto_step();
    @(negedge clk_i);
    mem_rvalid_i = pend;
    mem_rdata_i  = pend ? dat(pend_addr) : 32'h0;
    pend         = mem_req_o;
    pend_addr    = mem_addr_o;
    mem_gnt_i    = mem_req_o;
    #1;
  endtask

  task automatic man_step();
    @(negedge clk_i);
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; redirect_i = 1'b0;
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
`ifdef PFQ_BYPASS_EN
    byp = 1'b1;
`else
    byp = 1'b0;
`endif

    // streaming with continuous pop: in-order PCs, no gaps or repeats
    do_reset();
    start_i = 1'b1; pop_i = 1'b1; exp_pc = 32'h0;
    for (int i = 0; i < 20; i++) begin
      auto_step();
      if (inst_valid_o) begin
        chk("seq_pc", inst_pc_o, exp_pc);
        chk("seq_p4", pc_plus4_o, exp_pc + 32'd4);
        chk("seq_inst", inst_o, dat(exp_pc));
        exp_pc = exp_pc + 32'd4;
      end
    end
    chk("seq_count", exp_pc, byp ? 32'h28 : 32'h24);

    // fill to DEPTH with no pop, then one pop frees exactly one request
    do_reset();
    start_i = 1'b1;
    for (int i = 0; i < 12; i++) auto_step();
    chk("full_req", 32'(mem_req_o), 32'd0);
    chk("full_valid", 32'(inst_valid_o), 32'd1);
    chk("full_head", inst_pc_o, 32'h0);
    chk("full_addr", mem_addr_o, 32'h10);
    man_step();
    pop_i = 1'b1;
    chk("full_req2", 32'(mem_req_o), 32'd0);
    man_step();
    pop_i = 1'b0;
    chk("refill_req", 32'(mem_req_o), 32'd1);
    chk("refill_addr", mem_addr_o, 32'h10);
    chk("refill_head", inst_pc_o, 32'h4);
    mem_gnt_i = 1'b1;
    man_step();
    chk("refill_wait", 32'(mem_req_o), 32'd0);
    mem_rvalid_i = 1'b1; mem_rdata_i = dat(32'h10);
    man_step();
    chk("refill_full", 32'(mem_req_o), 32'd0);
    chk("refill_head2", inst_pc_o, 32'h4);

    // redirect + pop in WAIT with 2 entries and 0x8 outstanding
    do_reset();
    start_i = 1'b1;
    for (int i = 0; i < 5; i++) auto_step();
    man_step();
    chk("pre_redir_valid", 32'(inst_valid_o), 32'd1);
    chk("pre_redir_head", inst_pc_o, 32'h0);
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103; pop_i = 1'b1;
    man_step();
    pop_i = 1'b0;
    chk("redir_valid", 32'(inst_valid_o), 32'd0);
    chk("redir_inst", inst_o, 32'h0);
    chk("redir_pc", inst_pc_o, 32'h0);
    chk("redir_p4", pc_plus4_o, 32'h0);
    chk("drain_req", 32'(mem_req_o), 32'd0);
    mem_rvalid_i = 1'b1; mem_rdata_i = dat(32'h8);
    man_step();
    chk("drop_valid", 32'(inst_valid_o), 32'd0);
    chk("new_req", 32'(mem_req_o), 32'd1);
    chk("new_addr", mem_addr_o, 32'h100);
    mem_gnt_i = 1'b1;
    man_step();
    chk("new_wait", 32'(mem_req_o), 32'd0);
    mem_rvalid_i = 1'b1; mem_rdata_i = dat(32'h100);
    man_step();
    chk("new_valid", 32'(inst_valid_o), 32'd1);
    chk("new_pc", inst_pc_o, 32'h100);
    chk("new_p4", pc_plus4_o, 32'h104);
    chk("new_inst", inst_o, dat(32'h100));
    chk("next_addr", mem_addr_o, 32'h104);
    // redirect in the grant cycle: that response must be discarded
    mem_gnt_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h200;
    man_step();
    chk("gnt_redir_valid", 32'(inst_valid_o), 32'd0);
    chk("gnt_redir_req", 32'(mem_req_o), 32'd0);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    man_step();
    chk("gnt_drop_valid", 32'(inst_valid_o), 32'd0);
    chk("gnt_new_addr", mem_addr_o, 32'h200);
    // redirect in FETCH without grant: request reissued at new address
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0306;
    man_step();
    chk("withdraw_req", 32'(mem_req_o), 32'd1);
    chk("withdraw_addr", mem_addr_o, 32'h304);

    // async reset mid-WAIT, late response while IDLE ignored
    do_reset();
    start_i = 1'b1;
    for (int i = 0; i < 3; i++) auto_step();
    man_step();
    chk("mid_valid", 32'(inst_valid_o), 32'd1);
    rst_i = 1'b0; start_i = 1'b0;
    #1;
    chk("arst_valid", 32'(inst_valid_o), 32'd0);
    chk("arst_inst", inst_o, 32'h0);
    chk("arst_pc", inst_pc_o, 32'h0);
    chk("arst_p4", pc_plus4_o, 32'h0);
    chk("arst_req", 32'(mem_req_o), 32'd0);
    man_step();
    rst_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678;
    man_step();
    chk("late_valid", 32'(inst_valid_o), 32'd0);
    chk("late_req", 32'(mem_req_o), 32'd0);
    start_i = 1'b1;
    man_step();
    chk("restart_req", 32'(mem_req_o), 32'd1);
    chk("restart_addr", mem_addr_o, 32'h0);

    // empty queue, response with pop asserted
    do_reset();
    start_i = 1'b1;
    man_step();
    chk("byp_req", 32'(mem_req_o), 32'd1);
    mem_gnt_i = 1'b1;
    man_step();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h2008_0005; pop_i = 1'b1;
    #1;
    chk("byp_valid", 32'(inst_valid_o), byp ? 32'd1 : 32'd0);
    chk("byp_inst", inst_o, byp ? 32'h2008_0005 : 32'h0);
    chk("byp_p4", pc_plus4_o, byp ? 32'h4 : 32'h0);
    man_step();
    pop_i = 1'b0;
    #1;
    chk("byp_after_valid", 32'(inst_valid_o), byp ? 32'd0 : 32'd1);
    chk("byp_after_inst", inst_o, byp ? 32'h0 : 32'h2008_0005);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
